uart_rx_oversample: RTL and testbench
=====================================

Name: uart_rx_oversample

Overview:
- UART receive deserializer that is the receive-side counterpart to the existing transmit path.
- Synchronizes the asynchronous rx pin and times bits with a 16x oversampled tick.
- Majority-votes each bit, checks the stop bit, and presents bytes on a valid/ready handshake with a one-byte holding register.
- Sits between the board rx pin and the command/echo logic; flags framing errors and overruns.

Parameters:
- CLK_FRE, 50, system clock frequency in MHz.
- BAUD_RATE, 115200, line baud rate.
- OSR_DIV (localparam), CLK_FRE*1000000/(BAUD_RATE*16) truncated, clocks per oversample tick. The default is 27; 27 clocks per tick gives 432 clocks per bit.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_pin  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  received byte, LSB first on the line; held stable while rx_data_valid=1.
- rx_data_valid  output  1  holding register full.
- rx_data_ready  input  1  consumer accepts the byte when valid&&ready.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- overrun  output  1  one-cycle pulse when a good byte arrives while the holding register is full and not being drained.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values:
  - rx_data=0, rx_data_valid=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE; both synchronizer flops=1; tick and sub-bit counters=0; re-arm flag=1.
- Synchronizer: 2 flops on rx_pin, giving 2 cycles of latency. All decisions use the second flop (rxs).
- Tick generator:
  - Counter runs 0..OSR_DIV-1 and emits a tick on the OSR_DIV-1 cycle.
  - Held at 0 in IDLE; starts counting the cycle after leaving IDLE.
- Sub-bit counter: 0..15 and advances per tick. Bit counter: 0..7.
- Majority vote: samples taken at sub-bit ticks 7, 8 and 9. The bit value is the majority of the three, evaluated on the tick where sub=9.
- State IDLE: if rxs=0 and re-arm=1, go to START.
- State START:
  - At sub=9, a majority of 1 means a false start: return to IDLE with no output and no flags.
  - Otherwise continue; at sub=15 tick, go to DATA with bit=0.
- State DATA:
  - At sub=9, shift the voted bit into shift_reg[bit] (LSB first).
  - At sub=15 tick, bit++; after bit 7, go to STOP.
- State STOP: at sub=9, evaluate and go to IDLE the next cycle (half stop bit early, for resync).
  - Voted 1 (good byte):
    - If rx_data_valid=0, or valid&&ready in this same cycle: load rx_data=shift_reg and set rx_data_valid=1.
    - Else: drop the new byte, keep the old rx_data, and pulse overrun.
  - Voted 0 (framing error): pulse frame_err, discard the byte, leave the holding register untouched, and clear re-arm.
- Re-arm: cleared on a framing error and set when rxs=1 is seen in IDLE. A held-low break line therefore yields exactly one frame_err, not a stream.
- Handshake: rx_data_valid clears on the cycle after valid&&ready unless a new byte loads on that same cycle. rx_data_ready is ignored while valid=0.
- Latency: falling edge on rx_pin to rx_data_valid=1 is (9*16+10)*OSR_DIV + 4 clocks ±1. At defaults this is about 4162 clocks.
- Reset asserted mid-frame: everything returns to reset values immediately and the partial byte is lost. After deassert, a line that is still low starts a new frame; the bench checks no spurious valid.
- Pin glitch shorter than 7 ticks while in IDLE: produces no byte and no flags.

Test Plan:
- Send 0x55 at 115200 (432 clk/bit) with ready=1 -> rx_data=0x55, valid high for exactly 1 cycle, no flags, at about 4162 clocks after the edge.
- Send 0xA3 with ready=0, hold ready=0 for 1000 cycles, then assert ready -> valid stays 1 with rx_data=0xA3 throughout, then clears the cycle after ready.
- 100-clock low glitch on an idle line -> no valid, no frame_err, busy returns to 0 within about 250 clocks.
- Frame 0x3C with stop bit driven 0 -> frame_err single pulse, valid stays 0; then a 0x3C frame with a correct stop bit -> accepted.
- Hold ready=0 and send 0x11 then 0x22 -> rx_data=0x11 retained, one overrun pulse at the second stop.
- Hold the line low for 20 bit times, release, then send 0x7E -> exactly one frame_err, then 0x7E received.
- Assert rst during bit 4 of 0xF0, release while the line is high, then send 0x0F -> only 0x0F delivered.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// UART byte receiver: 2-flop pin synchronizer, 16x oversampling, 3-sample majority vote, stop check.
// Latency: pin falling edge to rx_data_valid is about (9*16+10)*OSR_DIV+4 clocks (4162 at defaults).
// Backpressure: one-byte holding register; a good byte arriving while it is full and not draining is dropped with overrun.
module uart_rx_oversample #(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int OSR_DIV = CLK_FRE * 1000000 / (BAUD_RATE * 16);
    localparam int TICK_W  = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OSR_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic              sync_q, rxs_q;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]        sub_q, sub_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [1:0]        vote_q, vote_d;
    logic              rearm_q, rearm_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_data_valid_q, rx_data_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              tick, bit_val, take;

    always_comb begin
        tick    = (state_q != IDLE) && (tick_cnt_q == TICK_LAST);
        // Samples from sub-ticks 7 and 8 are held; the third vote is the live sample at sub-tick 9.
        bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs_q) | (vote_q[1] & rxs_q);
        take    = rx_data_valid_q && rx_data_ready;

        state_d         = state_q;
        sub_d           = sub_q;
        bit_d           = bit_q;
        shift_d         = shift_q;
        vote_d          = vote_q;
        rearm_d         = rearm_q;
        rx_data_d       = rx_data_q;
        rx_data_valid_d = rx_data_valid_q && !take;
        frame_err_d     = 1'b0;
        overrun_d       = 1'b0;

        if (state_q == IDLE || tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        if (tick) begin
            sub_d = sub_q + 4'd1;
            if (sub_q == 4'd7) vote_d[0] = rxs_q;
            if (sub_q == 4'd8) vote_d[1] = rxs_q;
        end

        case (state_q)
            IDLE: begin
                sub_d = '0;
                bit_d = '0;
                if (rxs_q) begin
                    rearm_d = 1'b1;
                end else if (rearm_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick && sub_q == 4'd9 && bit_val) begin
                    state_d = IDLE;
                end else if (tick && sub_q == 4'd15) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick && sub_q == 4'd9) begin
                    shift_d[bit_q] = bit_val;
                end
                if (tick && sub_q == 4'd15) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Leave mid stop bit so the next start edge is never missed.
                if (tick && sub_q == 4'd9) begin
                    state_d = IDLE;
                    if (bit_val) begin
                        if (!rx_data_valid_q || take) begin
                            rx_data_d       = shift_q;
                            rx_data_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        rearm_d     = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q          <= 1'b1;
            rxs_q           <= 1'b1;
            state_q         <= IDLE;
            tick_cnt_q      <= '0;
            sub_q           <= '0;
            bit_q           <= '0;
            shift_q         <= '0;
            vote_q          <= '0;
            rearm_q         <= 1'b1;
            rx_data_q       <= '0;
            rx_data_valid_q <= 1'b0;
            frame_err_q     <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            sync_q          <= rx_pin;
            rxs_q           <= sync_q;
            state_q         <= state_d;
            tick_cnt_q      <= tick_cnt_d;
            sub_q           <= sub_d;
            bit_q           <= bit_d;
            shift_q         <= shift_d;
            vote_q          <= vote_d;
            rearm_q         <= rearm_d;
            rx_data_q       <= rx_data_d;
            rx_data_valid_q <= rx_data_valid_d;
            frame_err_q     <= frame_err_d;
            overrun_q       <= overrun_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_data_valid = rx_data_valid_q;
    assign frame_err     = frame_err_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: line-level frame driver, output monitor and a byte-level reference model.
module tb_uart_rx_oversample;
    localparam int OSR     = 50 * 1000000 / (115200 * 16);
    localparam int BIT     = OSR * 16;
    localparam int LAT_EXP = (9 * 16 + 10) * OSR + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_pin = 1'b1;
    logic       rx_data_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_valid, frame_err, overrun, busy;

    uart_rx_oversample dut (
        .clk           (clk),
        .rst           (rst),
        .rx_pin        (rx_pin),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .frame_err     (frame_err),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor
    byte unsigned got_q[$];
    int           ferr_cnt = 0;
    int           ovr_cnt  = 0;
    int           vld_run  = 0;
    int           last_run = 0;
    int unsigned  rise_cyc = 0;
    logic         prev_vld = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            vld_run  = 0;
            prev_vld = 1'b0;
        end else begin
            if (rx_data_valid && rx_data_ready) got_q.push_back(rx_data);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (rx_data_valid && !prev_vld) rise_cyc = cyc;
            if (rx_data_valid) begin
                vld_run++;
            end else if (vld_run != 0) begin
                last_run = vld_run;
                vld_run  = 0;
            end
            prev_vld = rx_data_valid;
        end
    end

    // Reference model: what the consumer should eventually see, at byte granularity.
    byte unsigned exp_q[$];
    int           exp_ferr = 0;
    int           exp_ovr  = 0;
    bit           m_full   = 1'b0;
    byte unsigned m_held   = 8'h00;

    task automatic model_frame(input byte unsigned d, input bit stop_ok);
        if (!stop_ok) begin
            exp_ferr++;
        end else if (m_full) begin
            exp_ovr++;
        end else if (rx_data_ready) begin
            exp_q.push_back(d);
        end else begin
            m_full = 1'b1;
            m_held = d;
        end
    endtask

    task automatic model_drain();
        if (m_full) begin
            exp_q.push_back(m_held);
            m_full = 1'b0;
        end
    endtask

    function automatic logic [31:0] last_got();
        return (got_q.size() == 0) ? 32'hFFFF_FFFF : {24'd0, got_q[got_q.size()-1]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line(input logic v, input int n);
        rx_pin = v;
        tick(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        line(1'b0, BIT);
        for (int i = 0; i < 8; i++) line(d[i], BIT);
        line(stop_bit, BIT);
        rx_pin = 1'b1;
    endtask

    int          n0, f0, o0, lat;
    int unsigned t0;
    logic [7:0]  rd;
    bit          rok;

    initial begin
        tick(5);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_data_valid, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick(20);

        // Single byte, ready held high
        t0 = cyc;
        model_frame(8'h55, 1'b1);
        send_frame(8'h55, 1'b1);
        tick(20);
        lat = int'(rise_cyc - t0);
        chk("s1_latency_in_window", (lat >= LAT_EXP - 2 && lat <= LAT_EXP + 2), 1'b1);
        chk("s1_count", got_q.size(), 1);
        chk("s1_data", last_got(), 8'h55);
        chk("s1_valid_len", last_run, 1);
        chk("s1_flags", ferr_cnt + ovr_cnt, 0);

        // Held byte under backpressure
        rx_data_ready = 1'b0;
        model_frame(8'hA3, 1'b1);
        send_frame(8'hA3, 1'b1);
        tick(10);
        for (int i = 0; i < 10; i++) begin
            tick(100);
            chk("s2_hold_valid", rx_data_valid, 1'b1);
            chk("s2_hold_data", rx_data, 8'hA3);
        end
        rx_data_ready = 1'b1;
        model_drain();
        chk("s2_valid_at_ready", rx_data_valid, 1'b1);
        tick(1);
        chk("s2_valid_cleared", rx_data_valid, 1'b0);
        chk("s2_data", last_got(), 8'hA3);

        // Short glitch on idle line
        n0 = got_q.size();
        f0 = ferr_cnt;
        line(1'b0, 50);
        chk("s3_busy_during", busy, 1'b1);
        line(1'b0, 50);
        rx_pin = 1'b1;
        tick(250);
        chk("s3_busy_after", busy, 1'b0);
        chk("s3_no_byte", got_q.size(), n0);
        chk("s3_no_ferr", ferr_cnt, f0);

        // Bad stop bit, then the same byte framed correctly
        f0 = ferr_cnt;
        model_frame(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0);
        tick(20);
        chk("s4_ferr", ferr_cnt - f0, 1);
        chk("s4_no_valid", rx_data_valid, 1'b0);
        chk("s4_no_byte", got_q.size(), n0);
        model_frame(8'h3C, 1'b1);
        send_frame(8'h3C, 1'b1);
        tick(20);
        chk("s4_good", last_got(), 8'h3C);

        // Overrun
        o0 = ovr_cnt;
        rx_data_ready = 1'b0;
        model_frame(8'h11, 1'b1);
        send_frame(8'h11, 1'b1);
        model_frame(8'h22, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(20);
        chk("s5_overrun", ovr_cnt - o0, 1);
        chk("s5_kept_data", rx_data, 8'h11);
        chk("s5_kept_valid", rx_data_valid, 1'b1);
        rx_data_ready = 1'b1;
        model_drain();
        tick(5);
        chk("s5_drained", last_got(), 8'h11);

        // Break: line low for 20 bit times
        f0 = ferr_cnt;
        n0 = got_q.size();
        model_frame(8'h00, 1'b0);
        line(1'b0, 20 * BIT);
        rx_pin = 1'b1;
        tick(100);
        chk("s6_one_ferr", ferr_cnt - f0, 1);
        chk("s6_no_byte", got_q.size(), n0);
        model_frame(8'h7E, 1'b1);
        send_frame(8'h7E, 1'b1);
        tick(20);
        chk("s6_after_break", last_got(), 8'h7E);

        // Reset in the middle of a frame
        n0 = got_q.size();
        fork
            send_frame(8'hF0, 1'b1);
        join_none
        tick(5 * BIT + BIT / 2);
        rst = 1'b1;
        tick(2);
        chk("s7_rst_data", rx_data, 8'h00);
        chk("s7_rst_valid", rx_data_valid, 1'b0);
        chk("s7_rst_busy", busy, 1'b0);
        tick(8);
        rst = 1'b0;
        wait fork;
        tick(100);
        chk("s7_idle", busy, 1'b0);
        chk("s7_no_partial", got_q.size(), n0);
        model_frame(8'h0F, 1'b1);
        send_frame(8'h0F, 1'b1);
        tick(20);
        chk("s7_count", got_q.size(), n0 + 1);
        chk("s7_data", last_got(), 8'h0F);

        // Random bytes, occasional bad stop bit
        for (int k = 0; k < 4; k++) begin
            rd  = 8'($urandom_range(0, 255));
            rok = ($urandom_range(0, 3) != 0);
            model_frame(rd, rok);
            send_frame(rd, rok);
            tick($urandom_range(1, 40));
        end
        tick(20);

        chk("final_bytes", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk("final_byte", got_q[i], exp_q[i]);
        end
        chk("final_ferr", ferr_cnt, exp_ferr);
        chk("final_ovr", ovr_cnt, exp_ovr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
